// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: PC generation, 1-cycle synchronous imem reads,
// and a DEPTH-entry first-word-fall-through {pc, inst} queue toward decode.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 8,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [31:0]        out_inst
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [XLEN-1:0]  pc_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_d [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];

  logic issue_c;
  logic push_c;
  logic pop_c;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Credit check counts the outstanding read so a full queue is never pushed.
  always_comb begin
    issue_c = rst && !redirect &&
              ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
    push_c  = inflight_q && !kill_q && !redirect;
    pop_c   = (count_q != '0) && out_ready;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    kill_d     = 1'b0;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      kill_d     = inflight_q;
    end else begin
      inflight_d = issue_c;
      if (issue_c) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        req_pc_d   = fetch_pc_q;
      end
      if (push_c) begin
        pc_mem_d[tail_q]   = req_pc_q;
        inst_mem_d[tail_q] = imem_rdata;
        tail_d             = tail_q + PTR_W'(1);
      end
      if (pop_c) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pc_mem_q   <= '{default: '0};
      inst_mem_q <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  // Head fields read zero whenever the queue is empty.
  always_comb begin
    imem_req  = issue_c;
    imem_addr = fetch_pc_q[IMEM_AW+1:2];
    out_valid = (count_q != '0);
    out_pc    = out_valid ? pc_mem_q[head_q] : '0;
    out_inst  = out_valid ? inst_mem_q[head_q] : '0;
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: vector table, hand-written redirect/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_queue_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  logic        w_req;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [11:0] w_pc;
  logic [31:0] w_inst;

  always #5 clk = ~clk;

  fetch_queue_stage #(.XLEN(32), .IMEM_AW(8), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  fetch_queue_stage #(.XLEN(12), .IMEM_AW(10), .DEPTH(DEPTH), .RESET_PC(12'hFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect(1'b0), .redirect_pc(12'h000),
    .out_valid(w_valid), .out_ready(1'b1), .out_pc(w_pc), .out_inst(w_inst)
  );

  function automatic logic [31:0] memword(input logic [9:0] a);
    return (32'h9E3779B9 * 32'(a)) ^ 32'h0BADF00D;
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) begin
    imem_rdata <= memword(10'(imem_addr));
    w_rdata    <= memword(w_addr);
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  logic        ws_valid;
  logic [11:0] ws_pc;
  logic [31:0] ws_inst;

  // One clock cycle: drive inputs, compare at negedge, return at posedge+1.
  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic ereq, input logic [7:0] eaddr, input logic ev,
                     input logic [31:0] epc, input string tag);
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    @(negedge clk);
    chk({tag, "_req"}, 32'(imem_req), 32'(ereq));
    chk({tag, "_addr"}, 32'(imem_addr), 32'(eaddr));
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({tag, "_pc"}, out_pc, epc);
      chk({tag, "_inst"}, out_inst, memword(10'(epc[9:2])));
    end
    if (dut.push_c) chk({tag, "_push_full"}, 32'(dut.count_q >= 3'(DEPTH) && !dut.pop_c), 32'd0);
    ws_valid = w_valid;
    ws_pc    = w_pc;
    ws_inst  = w_inst;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  bit          m_kill;

  function automatic bit m_req(input logic rd);
    return !rd && ((mq.size() + int'(m_pend)) < DEPTH);
  endfunction

  // Reference model: apply one clock edge of the fetch/queue rules.
  task automatic m_step(input logic rd, input logic [31:0] rpc, input logic rdy);
    bit issue;
    bit kill_n;
    issue  = m_req(rd);
    kill_n = 1'b0;
    if (rd) begin
      mq.delete();
      kill_n = m_pend;
      m_pend = 1'b0;
      m_fpc  = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_pend && !m_kill) mq.push_back('{pc: m_pend_pc, inst: memword(10'(m_pend_pc[9:2]))});
      if (issue) begin
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
      m_pend = issue;
    end
    m_kill = kill_n;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    m_fpc  = 32'h0;
    m_pend = 1'b0;
    m_kill = 1'b0;
  endtask

  typedef struct {
    bit          do_rst;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        ereq;
    logic [7:0]  eaddr;
    logic        ev;
    logic [31:0] epc;
    bit          wchk;
    logic        wv;
    logic [11:0] wpc;
  } vec_t;

  function automatic vec_t mk(bit r, logic rd, logic [31:0] rpc, logic rdy, logic ereq,
                              logic [7:0] ea, logic ev, logic [31:0] epc,
                              bit wc, logic wv, logic [11:0] wpc);
    return '{do_rst: r, rd: rd, rpc: rpc, rdy: rdy, ereq: ereq, eaddr: ea, ev: ev,
             epc: epc, wchk: wc, wv: wv, wpc: wpc};
  endfunction

  vec_t tbl[26];

  initial begin
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        prev_rd;

    // Reset release with out_ready=1, then redirect to 0x43.
    tbl[0]  = mk(1, 0, 0, 1, 1, 8'h00, 0, 32'h00, 1, 0, 12'h000);
    tbl[1]  = mk(0, 0, 0, 1, 1, 8'h01, 0, 32'h00, 1, 0, 12'h000);
    tbl[2]  = mk(0, 0, 0, 1, 1, 8'h02, 1, 32'h00, 1, 1, 12'hFF8);
    tbl[3]  = mk(0, 0, 0, 1, 1, 8'h03, 1, 32'h04, 1, 1, 12'hFFC);
    tbl[4]  = mk(0, 0, 0, 1, 1, 8'h04, 1, 32'h08, 1, 1, 12'h000);
    tbl[5]  = mk(0, 0, 0, 1, 1, 8'h05, 1, 32'h0C, 1, 1, 12'h004);
    tbl[6]  = mk(0, 1, 32'h43, 1, 0, 8'h06, 1, 32'h10, 0, 0, 12'h000);
    tbl[7]  = mk(0, 0, 0, 1, 1, 8'h10, 0, 32'h00, 0, 0, 12'h000);
    tbl[8]  = mk(0, 0, 0, 1, 1, 8'h11, 0, 32'h00, 0, 0, 12'h000);
    tbl[9]  = mk(0, 0, 0, 1, 1, 8'h12, 1, 32'h40, 0, 0, 12'h000);
    tbl[10] = mk(0, 0, 0, 1, 1, 8'h13, 1, 32'h44, 0, 0, 12'h000);
    // Backpressure: 10 cycles of out_ready=0, then drain.
    tbl[11] = mk(1, 0, 0, 0, 1, 8'h00, 0, 32'h00, 0, 0, 12'h000);
    tbl[12] = mk(0, 0, 0, 0, 1, 8'h01, 0, 32'h00, 0, 0, 12'h000);
    tbl[13] = mk(0, 0, 0, 0, 1, 8'h02, 1, 32'h00, 0, 0, 12'h000);
    tbl[14] = mk(0, 0, 0, 0, 1, 8'h03, 1, 32'h00, 0, 0, 12'h000);
    for (int i = 15; i < 21; i++) tbl[i] = mk(0, 0, 0, 0, 0, 8'h04, 1, 32'h00, 0, 0, 12'h000);
    tbl[21] = mk(0, 0, 0, 1, 0, 8'h04, 1, 32'h00, 0, 0, 12'h000);
    tbl[22] = mk(0, 0, 0, 1, 1, 8'h04, 1, 32'h04, 0, 0, 12'h000);
    tbl[23] = mk(0, 0, 0, 1, 1, 8'h05, 1, 32'h08, 0, 0, 12'h000);
    tbl[24] = mk(0, 0, 0, 1, 1, 8'h06, 1, 32'h0C, 0, 0, 12'h000);
    tbl[25] = mk(0, 0, 0, 1, 1, 8'h07, 1, 32'h10, 0, 0, 12'h000);

    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (tbl[i].do_rst) do_reset();
      cyc(tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].ereq, tbl[i].eaddr,
          tbl[i].ev, tbl[i].epc, $sformatf("vec%0d", i));
      if (tbl[i].wchk) begin
        chk($sformatf("vec%0d_wrap_valid", i), 32'(ws_valid), 32'(tbl[i].wv));
        if (tbl[i].wv) begin
          chk($sformatf("vec%0d_wrap_pc", i), 32'(ws_pc), 32'(tbl[i].wpc));
          chk($sformatf("vec%0d_wrap_inst", i), ws_inst, memword(tbl[i].wpc[11:2]));
        end
      end
    end

    // Redirect with 3 entries queued and a read in flight.
    do_reset();
    cyc(0, 0, 0, 1, 8'h00, 0, 32'h00, "rd3_c0");
    cyc(0, 0, 0, 1, 8'h01, 0, 32'h00, "rd3_c1");
    cyc(0, 0, 0, 1, 8'h02, 1, 32'h00, "rd3_c2");
    cyc(0, 0, 0, 1, 8'h03, 1, 32'h00, "rd3_c3");
    cyc(1, 32'h40, 0, 0, 8'h04, 1, 32'h00, "rd3_c4");
    cyc(0, 0, 0, 1, 8'h10, 0, 32'h00, "rd3_c5");
    cyc(0, 0, 0, 1, 8'h11, 0, 32'h00, "rd3_c6");
    cyc(0, 0, 0, 1, 8'h12, 1, 32'h40, "rd3_c7");
    cyc(0, 0, 1, 1, 8'h13, 1, 32'h40, "rd3_c8");
    cyc(0, 0, 1, 1, 8'h14, 1, 32'h44, "rd3_c9");
    cyc(0, 0, 1, 1, 8'h15, 1, 32'h48, "rd3_c10");

    // Mid-stream reset with entries queued and a read pending.
    do_reset();
    cyc(0, 0, 1, 1, 8'h00, 0, 32'h00, "mrst_c0");
    cyc(0, 0, 1, 1, 8'h01, 0, 32'h00, "mrst_c1");
    cyc(0, 0, 1, 1, 8'h02, 1, 32'h00, "mrst_c2");

    // Randomized traffic against the reference model.
    do_reset();
    prev_rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        prev_rd = 1'b0;
      end
      rd  = prev_rd ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      cyc(rd, rpc, rdy, m_req(rd), m_fpc[9:2], mq.size() != 0,
          (mq.size() != 0) ? mq[0].pc : 32'h0, $sformatf("rnd%0d", i));
      m_step(rd, rpc, rdy);
      prev_rd = rd;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
